apb_req_arbiter: RTL and testbench
==================================

# apb_req_arbiter

Two-requester APB master that shares one APB completer port (PADDR/PSEL/PENABLE/… bus) between two command sources. It arbitrates round-robin, runs the APB SETUP/ACCESS sequence for the winning command, and returns read data and error status to that requester. It guards against a stalled completer with an ACCESS-phase timeout. It sits between the testbench or CPU-side command sources and the APB FIFO/register DUT.

## Interface
Parameters:
- ADDR_W, 32, APB address width
- DATA_W, 32, APB data width; must be a multiple of 8
- TIMEOUT, 16, maximum number of ACCESS cycles before an abort; 0 disables the timeout

Ports:
- PCLK  in  1  clock; all logic updates on the rising edge
- PRESETn  in  1  asynchronous, active-low reset
- req_valid  in  2  command valid, one bit per requester
- req_ready  out  2  command accepted, one-hot, combinational
- req_addr  in  2*ADDR_W  per-requester address; requester i uses slice i
- req_write  in  2  1 = write, 0 = read
- req_wdata  in  2*DATA_W  write data
- req_strb  in  2*DATA_W/8  byte strobes
- req_prot  in  2*3  protection bits
- rsp_valid  out  2  one-cycle response pulse, one-hot, to the owning requester
- rsp_rdata  out  DATA_W  read data; 0 for writes and aborts
- rsp_err  out  1  PSLVERR, or timeout abort
- rsp_timeout  out  1  response was a timeout abort
- PADDR, PPROT, PSEL, PENABLE, PWRITE, PWDATA, PSTRB  out  ADDR_W, 3, 1, 1, 1, DATA_W, DATA_W/8  APB request
- PREADY, PRDATA, PSLVERR  in  1, DATA_W, 1  APB completion

## Operation
- State machine states: IDLE, SETUP, ACCESS.
- IDLE:
  - If any req_valid is high, grant one requester.
  - Raise req_ready[g] combinationally. Only one bit may be high, and only in IDLE.
  - On that edge, capture the requester's addr/write/wdata/strb/prot into the APB output registers.
  - Go to SETUP.
- Arbitration:
  - A last_grant register holds the most recent winner. It resets to 1, so requester 0 wins first.
  - If both requesters are valid, grant the one that is not last_grant.
  - If only one is valid, grant it.
  - Update last_grant on every grant.
- SETUP: PSEL=1, PENABLE=0, lasts exactly 1 cycle, then go to ACCESS.
- ACCESS:
  - PSEL=1, PENABLE=1.
  - On an edge where PREADY=1: register rsp_valid[g]=1, rsp_err=PSLVERR, rsp_timeout=0.
  - Set rsp_rdata=PRDATA for reads, 0 for writes.
  - Drop PSEL and PENABLE, then go to IDLE.
- Timeout (TIMEOUT>0):
  - A counter is cleared on entry to SETUP and increments on each ACCESS edge where PREADY=0.
  - If the counter reaches TIMEOUT, abort: drop PSEL and PENABLE, go to IDLE.
  - Respond with rsp_err=1, rsp_timeout=1, rsp_rdata=0.
  - If PREADY=1 on the same edge the counter reaches TIMEOUT, the transfer completes normally.
- PADDR, PWRITE, PWDATA, PSTRB and PPROT change only on an accept edge. They hold their value through SETUP, ACCESS and IDLE.
- rsp_valid, rsp_err, rsp_timeout and rsp_rdata are registered. They are valid for exactly one cycle, then clear to 0.
- Requesters must hold their request fields stable while req_valid is high until req_ready is seen. The arbiter does not re-check those fields after accept.
- Reset at any time:
  - All outputs, the state machine, the counter and last_grant are cleared immediately. Outputs go to 0, the state to IDLE, last_grant to 1.
  - An in-flight command is dropped and no rsp_valid is issued.

## Timing
- Accept at edge 0 → SETUP in cycle 1 → ACCESS from cycle 2.
- PREADY=1 in cycle 2+k (k wait states) → rsp_valid in cycle 3+k, concurrent with IDLE.
- In that same cycle a new request may be accepted, so its SETUP is cycle 4+k.
- Minimum spacing is 3 cycles per transfer. There is always one PSEL=0 cycle between transfers.
- Abort: ACCESS lasts at most TIMEOUT cycles, and rsp_valid follows in the next cycle.
- Reset values: every output is 0.

## Test plan
- Reset: hold PRESETn=0 → all outputs 0. Release with no requests → PSEL remains 0.
- Single write:
  - Stimulus: requester 0 writes addr 0x10, data 0xA5A50001, strb 0xF, with PREADY tied to 1.
  - Required response: PSEL=1 in cycle 1; PENABLE=1 in cycle 2; rsp_valid=2'b01 in cycle 3; rsp_err=0; rsp_rdata=0.
- Contention:
  - Stimulus: both requesters continuously issue reads, to 0x0 and 0x4. The completer returns 0x1111 for address 0x0 and 0x2222 for address 0x4.
  - Required response: grant order 0,1,0,1. rsp_valid=01 carries 0x1111 and rsp_valid=10 carries 0x2222.
- Wait states and error:
  - Stimulus: PREADY held low for 3 ACCESS cycles, then PREADY=1 with PSLVERR=1.
  - Required response: ACCESS lasts 4 cycles with PADDR/PWDATA stable; rsp_err=1; rsp_timeout=0.
- Timeout:
  - Stimulus: TIMEOUT=4, PREADY never asserted.
  - Required response: PENABLE is high in cycles 2–5; PSEL=0 in cycle 6; rsp_err=rsp_timeout=1; rsp_rdata=0.
  - The next request proceeds normally.
- Reset mid-transfer:
  - Stimulus: drive PRESETn low during ACCESS.
  - Required response: PSEL and PENABLE go to 0 immediately, without waiting for an edge; no rsp_valid. After release, with both requesters valid, requester 0 is granted first.

Source files
------------

// File: rtl/apb_req_arbiter.sv
// Round-robin arbiter that lets two command sources share one APB completer.
// It runs the SETUP/ACCESS handshake and can abort a transfer when the completer stalls.
//
// state  | meaning
// IDLE   | no transfer in flight; a valid request is granted and captured
// SETUP  | PSEL=1, PENABLE=0 for exactly one cycle
// ACCESS | PSEL=1, PENABLE=1 until PREADY or timeout abort
module apb_req_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                    PCLK,
  input  logic                    PRESETn,
  input  logic [1:0]              req_valid,
  output logic [1:0]              req_ready,
  input  logic [2*ADDR_W-1:0]     req_addr,
  input  logic [1:0]              req_write,
  input  logic [2*DATA_W-1:0]     req_wdata,
  input  logic [2*(DATA_W/8)-1:0] req_strb,
  input  logic [5:0]              req_prot,
  output logic [1:0]              rsp_valid,
  output logic [DATA_W-1:0]       rsp_rdata,
  output logic                    rsp_err,
  output logic                    rsp_timeout,
  output logic [ADDR_W-1:0]       PADDR,
  output logic [2:0]              PPROT,
  output logic                    PSEL,
  output logic                    PENABLE,
  output logic                    PWRITE,
  output logic [DATA_W-1:0]       PWDATA,
  output logic [DATA_W/8-1:0]     PSTRB,
  input  logic                    PREADY,
  input  logic [DATA_W-1:0]       PRDATA,
  input  logic                    PSLVERR
);

  localparam int STRB_W = DATA_W / 8;
  localparam int CNT_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETUP  = 2'd1;
  localparam logic [1:0] ACCESS = 2'd2;

  logic [1:0]        state_q, state_d;
  logic              last_grant_q, last_grant_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [2:0]        pprot_q, pprot_d;
  logic              pwrite_q, pwrite_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic [STRB_W-1:0] pstrb_q, pstrb_d;
  logic [1:0]        rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;
  logic              rsp_timeout_q, rsp_timeout_d;

  logic gnt;
  logic accept;

  // With both requesters pending, the one that did not win last time goes next.
  always_comb begin
    gnt       = (&req_valid) ? ~last_grant_q : req_valid[1];
    accept    = PRESETn && (state_q == IDLE) && (|req_valid);
    req_ready = accept ? (gnt ? 2'b10 : 2'b01) : 2'b00;
  end

  always_comb begin
    state_d       = state_q;
    last_grant_d  = last_grant_q;
    cnt_d         = cnt_q;
    paddr_d       = paddr_q;
    pprot_d       = pprot_q;
    pwrite_d      = pwrite_q;
    pwdata_d      = pwdata_q;
    pstrb_d       = pstrb_q;
    rsp_valid_d   = 2'b00;
    rsp_rdata_d   = '0;
    rsp_err_d     = 1'b0;
    rsp_timeout_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          last_grant_d = gnt;
          paddr_d  = gnt ? req_addr[2*ADDR_W-1:ADDR_W]   : req_addr[ADDR_W-1:0];
          pwdata_d = gnt ? req_wdata[2*DATA_W-1:DATA_W]  : req_wdata[DATA_W-1:0];
          pstrb_d  = gnt ? req_strb[2*STRB_W-1:STRB_W]   : req_strb[STRB_W-1:0];
          pprot_d  = gnt ? req_prot[5:3]                 : req_prot[2:0];
          pwrite_d = gnt ? req_write[1]                  : req_write[0];
          cnt_d    = CNT_W'(TIMEOUT);
          state_d  = SETUP;
        end
      end
      SETUP: state_d = ACCESS;
      ACCESS: begin
        // PREADY wins over an expiring timer on the same edge.
        if (PREADY) begin
          rsp_valid_d = last_grant_q ? 2'b10 : 2'b01;
          rsp_err_d   = PSLVERR;
          rsp_rdata_d = pwrite_q ? '0 : PRDATA;
          state_d     = IDLE;
        end else if (TIMEOUT > 0) begin
          if (cnt_q == CNT_W'(1)) begin
            rsp_valid_d   = last_grant_q ? 2'b10 : 2'b01;
            rsp_err_d     = 1'b1;
            rsp_timeout_d = 1'b1;
            state_d       = IDLE;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q       <= IDLE;
      last_grant_q  <= 1'b1;
      cnt_q         <= '0;
      paddr_q       <= '0;
      pprot_q       <= '0;
      pwrite_q      <= 1'b0;
      pwdata_q      <= '0;
      pstrb_q       <= '0;
      rsp_valid_q   <= 2'b00;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_grant_q  <= last_grant_d;
      cnt_q         <= cnt_d;
      paddr_q       <= paddr_d;
      pprot_q       <= pprot_d;
      pwrite_q      <= pwrite_d;
      pwdata_q      <= pwdata_d;
      pstrb_q       <= pstrb_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  assign PSEL        = (state_q != IDLE);
  assign PENABLE     = (state_q == ACCESS);
  assign PADDR       = paddr_q;
  assign PPROT       = pprot_q;
  assign PWRITE      = pwrite_q;
  assign PWDATA      = pwdata_q;
  assign PSTRB       = pstrb_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Bench for apb_req_arbiter: directed scenarios, a transaction-level model
// checked every cycle, and literal expectations for the key cycles.
module tb_apb_req_arbiter;

  localparam int TO = 4;

  logic        PCLK = 1'b0;
  logic        PRESETn;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [63:0] req_addr;
  logic [1:0]  req_write;
  logic [63:0] req_wdata;
  logic [7:0]  req_strb;
  logic [5:0]  req_prot;
  logic [1:0]  rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err, rsp_timeout;
  logic [31:0] PADDR, PWDATA, PRDATA;
  logic [2:0]  PPROT;
  logic [3:0]  PSTRB;
  logic        PSEL, PENABLE, PWRITE, PREADY, PSLVERR;

  int n_checks = 0;
  int n_fail   = 0;

  int wait_n   = 0;
  int acc_cnt  = 0;
  logic slverr_ctl = 1'b0;

  apb_req_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_write(req_write), .req_wdata(req_wdata), .req_strb(req_strb),
    .req_prot(req_prot), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .PADDR(PADDR), .PPROT(PPROT), .PSEL(PSEL), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PWDATA(PWDATA), .PSTRB(PSTRB),
    .PREADY(PREADY), .PRDATA(PRDATA), .PSLVERR(PSLVERR)
  );

  always #5 PCLK = ~PCLK;

  function automatic logic [31:0] rd_fn(input logic [31:0] a);
    if (a == 32'h0) return 32'h1111;
    if (a == 32'h4) return 32'h2222;
    return 32'hC0DE0000 | {16'h0, a[15:0]};
  endfunction

  // Completer: answers after wait_n stalled ACCESS cycles; wait_n<0 never answers.
  assign PRDATA  = rd_fn(PADDR);
  assign PSLVERR = slverr_ctl;
  always_comb PREADY = PSEL && PENABLE && (wait_n >= 0) && (acc_cnt >= wait_n);

  always @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) acc_cnt <= 0;
    else if (PSEL && PENABLE && !PREADY) acc_cnt <= acc_cnt + 1;
    else acc_cnt <= 0;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Transaction-level model: one transfer in flight, timed by its age in cycles.
  bit          m_busy = 0;
  int          m_age  = 0;
  int          m_acc  = 0;
  bit          m_last = 1;
  bit          m_owner = 0;
  logic [31:0] m_addr = 0, m_wdata = 0;
  logic        m_write = 0;
  logic [3:0]  m_strb = 0;
  logic [2:0]  m_prot = 0;
  logic [1:0]  e_rsp_valid = 0;
  logic [31:0] e_rsp_rdata = 0;
  logic        e_rsp_err = 0, e_rsp_to = 0;
  logic [1:0]  e_ready;
  bit          pick;

  logic [1:0]  log_owner[$];
  logic [31:0] log_data[$];

  always @(negedge PCLK) begin
    if (!PRESETn) begin
      m_busy = 0; m_age = 0; m_acc = 0; m_last = 1; m_owner = 0;
      m_addr = 0; m_wdata = 0; m_write = 0; m_strb = 0; m_prot = 0;
      e_rsp_valid = 0; e_rsp_rdata = 0; e_rsp_err = 0; e_rsp_to = 0;
    end
    pick    = (req_valid == 2'b11) ? !m_last : req_valid[1];
    e_ready = (PRESETn && !m_busy && req_valid != 2'b00) ? (pick ? 2'b10 : 2'b01) : 2'b00;

    chk("m_req_ready", req_ready, e_ready);
    chk("m_psel", PSEL, m_busy);
    chk("m_penable", PENABLE, m_busy && m_age >= 2);
    chk("m_paddr", PADDR, m_addr);
    chk("m_pwdata", PWDATA, m_wdata);
    chk("m_pwrite", PWRITE, m_write);
    chk("m_pstrb", PSTRB, m_strb);
    chk("m_pprot", PPROT, m_prot);
    chk("m_rsp_valid", rsp_valid, e_rsp_valid);
    chk("m_rsp_rdata", rsp_rdata, e_rsp_rdata);
    chk("m_rsp_err", rsp_err, e_rsp_err);
    chk("m_rsp_timeout", rsp_timeout, e_rsp_to);
    if (rsp_valid != 2'b00) begin
      log_owner.push_back(rsp_valid);
      log_data.push_back(rsp_rdata);
    end

    e_rsp_valid = 0; e_rsp_rdata = 0; e_rsp_err = 0; e_rsp_to = 0;
    if (PRESETn) begin
      if (!m_busy) begin
        if (req_valid != 2'b00) begin
          m_owner = pick; m_last = pick;
          m_addr  = req_addr[int'(pick)*32 +: 32];
          m_wdata = req_wdata[int'(pick)*32 +: 32];
          m_strb  = req_strb[int'(pick)*4 +: 4];
          m_prot  = req_prot[int'(pick)*3 +: 3];
          m_write = req_write[pick];
          m_busy = 1; m_age = 1; m_acc = 0;
        end
      end else if (m_age == 1) begin
        m_age = 2;
      end else if (PREADY) begin
        e_rsp_valid = m_owner ? 2'b10 : 2'b01;
        e_rsp_err   = PSLVERR;
        e_rsp_rdata = m_write ? 32'h0 : rd_fn(m_addr);
        m_busy = 0;
      end else begin
        m_acc++;
        if (TO > 0 && m_acc == TO) begin
          e_rsp_valid = m_owner ? 2'b10 : 2'b01;
          e_rsp_err = 1; e_rsp_to = 1;
          m_busy = 0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  task automatic set_req(input int i, input logic wr, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] s, input logic [2:0] p);
    req_addr[i*32 +: 32]  = a;
    req_write[i]          = wr;
    req_wdata[i*32 +: 32] = d;
    req_strb[i*4 +: 4]    = s;
    req_prot[i*3 +: 3]    = p;
  endtask

  initial begin
    PRESETn = 1'b0; req_valid = 2'b00; req_addr = '0; req_write = '0;
    req_wdata = '0; req_strb = '0; req_prot = '0;

    // Reset state
    repeat (2) @(negedge PCLK);
    chk("rst_psel", PSEL, 0);
    chk("rst_penable", PENABLE, 0);
    chk("rst_paddr", PADDR, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    tick(); PRESETn = 1'b1;
    repeat (3) begin @(negedge PCLK); chk("idle_psel", PSEL, 0); end

    // Single write from requester 0
    tick();
    set_req(0, 1'b1, 32'h10, 32'hA5A50001, 4'hF, 3'b000);
    req_valid = 2'b01; wait_n = 0;
    @(negedge PCLK); chk("wr_ready", req_ready, 2'b01);
    tick(); req_valid = 2'b00;
    @(negedge PCLK); chk("wr_c1_psel", PSEL, 1); chk("wr_c1_pen", PENABLE, 0);
    @(negedge PCLK); chk("wr_c2_pen", PENABLE, 1); chk("wr_c2_pwdata", PWDATA, 32'hA5A50001);
    @(negedge PCLK);
    chk("wr_c3_rsp_valid", rsp_valid, 2'b01);
    chk("wr_c3_rsp_err", rsp_err, 0);
    chk("wr_c3_rsp_rdata", rsp_rdata, 0);
    chk("wr_c3_psel", PSEL, 0);

    // Wait states ending in PSLVERR, from requester 1
    tick();
    set_req(1, 1'b1, 32'h20, 32'h12345678, 4'h3, 3'b101);
    req_valid = 2'b10; wait_n = 3; slverr_ctl = 1'b1;
    tick(); req_valid = 2'b00;
    for (int c = 1; c <= 6; c++) begin
      @(negedge PCLK);
      chk("ws_penable", PENABLE, (c >= 2 && c <= 5));
      if (c == 5) chk("ws_paddr", PADDR, 32'h20);
      if (c == 6) begin
        chk("ws_rsp_valid", rsp_valid, 2'b10);
        chk("ws_rsp_err", rsp_err, 1);
        chk("ws_rsp_timeout", rsp_timeout, 0);
      end
    end
    slverr_ctl = 1'b0;

    // Timeout abort, then a normal transfer
    tick();
    set_req(0, 1'b0, 32'h8, 32'h0, 4'hF, 3'b000);
    req_valid = 2'b01; wait_n = -1;
    tick(); req_valid = 2'b00;
    for (int c = 1; c <= 6; c++) begin
      @(negedge PCLK);
      chk("to_penable", PENABLE, (c >= 2 && c <= 5));
      chk("to_psel", PSEL, (c <= 5));
      if (c == 6) begin
        chk("to_rsp_valid", rsp_valid, 2'b01);
        chk("to_rsp_err", rsp_err, 1);
        chk("to_rsp_timeout", rsp_timeout, 1);
        chk("to_rsp_rdata", rsp_rdata, 0);
      end
    end
    tick();
    wait_n = 0;
    set_req(1, 1'b0, 32'h4, 32'h0, 4'hF, 3'b000);
    req_valid = 2'b10;
    tick(); req_valid = 2'b00;
    for (int c = 1; c <= 3; c++) begin
      @(negedge PCLK);
      if (c == 3) begin
        chk("after_to_rsp_valid", rsp_valid, 2'b10);
        chk("after_to_rsp_rdata", rsp_rdata, 32'h2222);
        chk("after_to_rsp_err", rsp_err, 0);
      end
    end

    // Contention after a fresh reset
    tick(); PRESETn = 1'b0;
    tick(); PRESETn = 1'b1;
    set_req(0, 1'b0, 32'h0, 32'h0, 4'hF, 3'b000);
    set_req(1, 1'b0, 32'h4, 32'h0, 4'hF, 3'b000);
    wait_n = 0;
    log_owner.delete(); log_data.delete();
    req_valid = 2'b11;
    repeat (10) @(posedge PCLK);
    #1 req_valid = 2'b00;
    repeat (5) tick();
    chk("cont_count", log_owner.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < log_owner.size()) begin
        chk("cont_owner", log_owner[i], (i % 2 == 0) ? 2'b01 : 2'b10);
        chk("cont_rdata", log_data[i], (i % 2 == 0) ? 32'h1111 : 32'h2222);
      end
    end

    // Reset during ACCESS
    tick();
    set_req(0, 1'b1, 32'h30, 32'hDEAD0000, 4'hF, 3'b000);
    req_valid = 2'b01; wait_n = -1;
    tick(); req_valid = 2'b00;
    tick(); tick();
    chk("mid_pen_before", PENABLE, 1);
    #1 PRESETn = 1'b0;
    #1;
    chk("mid_psel", PSEL, 0);
    chk("mid_penable", PENABLE, 0);
    chk("mid_rsp_valid", rsp_valid, 0);
    set_req(0, 1'b0, 32'h0, 32'h0, 4'hF, 3'b000);
    set_req(1, 1'b0, 32'h4, 32'h0, 4'hF, 3'b000);
    req_valid = 2'b11;
    tick(); tick();
    PRESETn = 1'b1; wait_n = 0;
    @(negedge PCLK); chk("mid_first_grant", req_ready, 2'b01);
    tick(); req_valid = 2'b10;
    repeat (3) tick();
    req_valid = 2'b00;
    repeat (4) tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
